// File: rtl/q_job_sequencer_if.sv
// ============================================================================
// Module      : q_job_sequencer_if
// Description : Operand/result valid-ready channels and compute-core
//               start/done bus for the Q job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface q_job_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] N;
  logic              N_valid;
  logic              N_ready;
  logic [DATA_W-1:0] X;
  logic              X_valid;
  logic              X_ready;
  logic [DATA_W-1:0] T;
  logic              T_valid;
  logic              T_ready;
  logic [DATA_W-1:0] Q;
  logic              Q_valid;
  logic              Q_ready;
  logic              core_start;
  logic [DATA_W-1:0] core_n;
  logic [DATA_W-1:0] core_x;
  logic [DATA_W-1:0] core_t;
  logic              core_done;
  logic [DATA_W-1:0] core_q;
  logic [15:0]       job_count;
  logic              busy;
  logic              err;

  // Environment side: operand sources, result sink and compute core.
  modport master (
    output N, N_valid, X, X_valid, T, T_valid, Q_ready, core_done, core_q,
    input  N_ready, X_ready, T_ready, Q, Q_valid, core_start,
    input  core_n, core_x, core_t, job_count, busy, err
  );

  // Sequencer side.
  modport slave (
    input  N, N_valid, X, X_valid, T, T_valid, Q_ready, core_done, core_q,
    output N_ready, X_ready, T_ready, Q, Q_valid, core_start,
    output core_n, core_x, core_t, job_count, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/q_job_sequencer.sv
// ============================================================================
// Module      : q_job_sequencer
// Description : Collects sticky N/X operands, launches one compute-core job
//               per accepted T and returns Q. Optional watchdog on the core
//               wait is enabled with macro Q_SEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_job_sequencer #(
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] N_RESET        = '0,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_PATTERN    = 32'h7FC0_0000
) (
  input  wire logic             aclk,
  input  wire logic             aresetn,
  q_job_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_core_n;
  logic [DATA_W-1:0] r_core_x;
  logic [DATA_W-1:0] r_core_t;
  logic [DATA_W-1:0] r_q;
  logic              r_q_valid;
  logic              r_x_loaded;
  logic [15:0]       r_job_count;

  logic              w_n_ready;
  logic              w_x_ready;
  logic              w_t_ready;
  logic              w_core_start;
  logic              w_busy;
  logic              w_n_fire;
  logic              w_x_fire;
  logic              w_t_fire;
  logic              w_done;
  logic              w_q_fire;
  logic              w_timeout;

  // ---------------------------------------------------------------------------
  // Optional watchdog on the WAIT state
  // ---------------------------------------------------------------------------
`ifdef Q_SEQ_WATCHDOG_EN
  localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_err;

  // Last WAIT cycle before the limit; a simultaneous core_done takes priority.
  assign w_timeout = (r_state == S_WAIT) && !bus.core_done &&
                     (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_wd;

  assign w_timeout   = 1'b0;
  assign w_unused_wd = ^{ERR_PATTERN, TIMEOUT_CYCLES[0]};
  assign bus.err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_n_ready    = 1'b0;
    w_x_ready    = 1'b0;
    w_t_ready    = 1'b0;
    w_core_start = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        // Readies are state decodes, forced low while reset is asserted.
        w_n_ready = aresetn;
        w_x_ready = aresetn;
        w_t_ready = aresetn && r_x_loaded;
        w_busy    = 1'b0;
        if (w_t_fire) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_core_start = 1'b1;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done || w_timeout) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.Q_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_n_fire = bus.N_valid && w_n_ready;
  assign w_x_fire = bus.X_valid && w_x_ready;
  assign w_t_fire = bus.T_valid && w_t_ready;
  // core_done counts only in WAIT; pulses in ISSUE, OUT or IDLE are dropped.
  assign w_done   = (r_state == S_WAIT) && bus.core_done;
  assign w_q_fire = (r_state == S_OUT) && bus.Q_ready;

  // ---------------------------------------------------------------------------
  // Operand, result and job-count registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_core_n    <= N_RESET;
      r_core_x    <= '0;
      r_core_t    <= '0;
      r_x_loaded  <= 1'b0;
      r_q         <= '0;
      r_q_valid   <= 1'b0;
      r_job_count <= 16'd0;
    end else begin
      if (w_n_fire) begin
        r_core_n <= bus.N;
      end
      if (w_x_fire) begin
        r_core_x   <= bus.X;
        r_x_loaded <= 1'b1;
      end
      if (w_t_fire) begin
        r_core_t <= bus.T;
      end
      if (w_done) begin
        r_q       <= bus.core_q;
        r_q_valid <= 1'b1;
      end else if (w_timeout) begin
        r_q       <= ERR_PATTERN;
        r_q_valid <= 1'b1;
      end
      if (w_q_fire) begin
        r_q_valid   <= 1'b0;
        r_job_count <= r_job_count + 16'd1;
      end
    end
  end

  assign bus.N_ready    = w_n_ready;
  assign bus.X_ready    = w_x_ready;
  assign bus.T_ready    = w_t_ready;
  assign bus.Q          = r_q;
  assign bus.Q_valid    = r_q_valid;
  assign bus.core_start = w_core_start;
  assign bus.core_n     = r_core_n;
  assign bus.core_x     = r_core_x;
  assign bus.core_t     = r_core_t;
  assign bus.job_count  = r_job_count;
  assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_q_job_sequencer.sv
// ============================================================================
// Module      : tb_q_job_sequencer
// Description : Directed self-checking bench for q_job_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_job_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   start_cnt;

  q_job_sequencer_if #(.DATA_W(32)) bus ();

  q_job_sequencer #(
    .DATA_W        (32),
    .N_RESET       (32'h0),
    .TIMEOUT_CYCLES(16),
    .ERR_PATTERN   (32'h7FC0_0000)
  ) dut (
    .aclk   (clk),
    .aresetn(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.core_start === 1'b1) start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.N = '0; bus.N_valid = 1'b0;
    bus.X = '0; bus.X_valid = 1'b0;
    bus.T = '0; bus.T_valid = 1'b0;
    bus.Q_ready = 1'b0; bus.core_done = 1'b0; bus.core_q = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.Q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h exp %h", bus.Q, 32'h0); end
    checks++; if (bus.Q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b exp 0", bus.Q_valid); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b exp 0", bus.core_start); end
    checks++; if ({bus.core_n, bus.core_x, bus.core_t} !== 96'h0) begin errors++; $display("FAIL reset_operands: got %h exp 0", {bus.core_n, bus.core_x, bus.core_t}); end
    checks++; if (bus.job_count !== 16'd0) begin errors++; $display("FAIL reset_job_count: got %0d exp 0", bus.job_count); end
    checks++; if ({bus.busy, bus.err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b exp 00", {bus.busy, bus.err}); end
    checks++; if ({bus.N_ready, bus.X_ready, bus.T_ready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b exp 000", {bus.N_ready, bus.X_ready, bus.T_ready}); end
    rst_n = 1'b1;
    tick();
    checks++; if ({bus.N_ready, bus.X_ready, bus.T_ready} !== 3'b110) begin errors++; $display("FAIL idle_readies: got %b exp 110", {bus.N_ready, bus.X_ready, bus.T_ready}); end
  endtask

  task automatic test_basic_job();
    int starts0;
    bus.X = 32'd1; bus.X_valid = 1'b1;
    tick();
    bus.X_valid = 1'b0;
    checks++; if (bus.T_ready !== 1'b1) begin errors++; $display("FAIL basic_t_ready: got %b exp 1", bus.T_ready); end
    starts0 = start_cnt;
    bus.T = 32'd2; bus.T_valid = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL basic_core_start: got %b exp 1", bus.core_start); end
    checks++; if ({bus.core_n, bus.core_x, bus.core_t} !== {32'd0, 32'd1, 32'd2}) begin errors++; $display("FAIL basic_operands: got %h exp %h", {bus.core_n, bus.core_x, bus.core_t}, {32'd0, 32'd1, 32'd2}); end
    bus.Q_ready = 1'b1;
    tick();
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse: got %b exp 0", bus.core_start); end
    repeat (4) begin
      tick();
      checks++; if (bus.Q_valid !== 1'b0) begin errors++; $display("FAIL basic_early_q_valid: got %b exp 0", bus.Q_valid); end
    end
    bus.core_done = 1'b1; bus.core_q = 32'h3;
    tick();
    bus.core_done = 1'b0;
    checks++; if ({bus.Q_valid, bus.Q} !== {1'b1, 32'h3}) begin errors++; $display("FAIL basic_q: got %h exp %h", {bus.Q_valid, bus.Q}, {1'b1, 32'h3}); end
    checks++; if (bus.job_count !== 16'd0) begin errors++; $display("FAIL basic_count_early: got %0d exp 0", bus.job_count); end
    tick();
    checks++; if (bus.Q_valid !== 1'b0) begin errors++; $display("FAIL basic_q_valid_drop: got %b exp 0", bus.Q_valid); end
    checks++; if (bus.job_count !== 16'd1) begin errors++; $display("FAIL basic_job_count: got %0d exp 1", bus.job_count); end
    checks++; if (start_cnt - starts0 !== 1) begin errors++; $display("FAIL basic_start_count: got %0d exp 1", start_cnt - starts0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b exp 0", bus.busy); end
  endtask

  task automatic test_t_before_x();
    apply_reset();
    bus.T = 32'd6; bus.T_valid = 1'b1;
    repeat (3) begin
      tick();
      checks++; if ({bus.T_ready, bus.busy} !== 2'b00) begin errors++; $display("FAIL tbx_t_ready_low: got %b exp 00", {bus.T_ready, bus.busy}); end
    end
    bus.X = 32'd5; bus.X_valid = 1'b1;
    tick();
    bus.X_valid = 1'b0;
    checks++; if (bus.T_ready !== 1'b1) begin errors++; $display("FAIL tbx_t_ready_high: got %b exp 1", bus.T_ready); end
    tick();
    bus.T_valid = 1'b0;
    checks++; if ({bus.core_start, bus.core_x, bus.core_t} !== {1'b1, 32'd5, 32'd6}) begin errors++; $display("FAIL tbx_launch: got %h exp %h", {bus.core_start, bus.core_x, bus.core_t}, {1'b1, 32'd5, 32'd6}); end
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'hAB; bus.Q_ready = 1'b1;
    tick();
    bus.core_done = 1'b0;
    checks++; if (bus.Q !== 32'hAB) begin errors++; $display("FAIL tbx_q: got %h exp %h", bus.Q, 32'hAB); end
    tick();
    checks++; if (bus.job_count !== 16'd1) begin errors++; $display("FAIL tbx_job_count: got %0d exp 1", bus.job_count); end
  endtask

  task automatic test_backpressure();
    bus.Q_ready = 1'b0;
    bus.X = 32'd2; bus.X_valid = 1'b1;
    tick();
    bus.X_valid = 1'b0;
    bus.T = 32'd4; bus.T_valid = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    checks++; if ({bus.core_x, bus.core_t} !== {32'd2, 32'd4}) begin errors++; $display("FAIL bp_operands: got %h exp %h", {bus.core_x, bus.core_t}, {32'd2, 32'd4}); end
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'hDEAD_BEEF;
    tick();
    bus.N = 32'd99; bus.N_valid = 1'b1; bus.X_valid = 1'b1; bus.T_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.core_done = (i == 4); bus.core_q = 32'h1234;
      tick();
      checks++; if ({bus.Q_valid, bus.Q} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL bp_q_hold[%0d]: got %h exp %h", i, {bus.Q_valid, bus.Q}, {1'b1, 32'hDEAD_BEEF}); end
      checks++; if ({bus.N_ready, bus.X_ready, bus.T_ready} !== 3'b000) begin errors++; $display("FAIL bp_readies[%0d]: got %b exp 000", i, {bus.N_ready, bus.X_ready, bus.T_ready}); end
      checks++; if (bus.job_count !== 16'd1) begin errors++; $display("FAIL bp_count_hold[%0d]: got %0d exp 1", i, bus.job_count); end
    end
    bus.N_valid = 1'b0; bus.X_valid = 1'b0; bus.T_valid = 1'b0; bus.core_done = 1'b0;
    bus.Q_ready = 1'b1;
    tick();
    checks++; if ({bus.Q_valid, bus.job_count} !== {1'b0, 16'd2}) begin errors++; $display("FAIL bp_release: got %h exp %h", {bus.Q_valid, bus.job_count}, {1'b0, 16'd2}); end
    checks++; if (bus.core_n !== 32'd0) begin errors++; $display("FAIL bp_n_not_taken: got %h exp 0", bus.core_n); end
  endtask

  task automatic test_simultaneous();
    bus.N = 32'd7; bus.X = 32'd9; bus.T = 32'd11;
    bus.N_valid = 1'b1; bus.X_valid = 1'b1; bus.T_valid = 1'b1;
    tick();
    bus.N_valid = 1'b0; bus.X_valid = 1'b0; bus.T_valid = 1'b0;
    checks++; if ({bus.core_start, bus.core_n, bus.core_x, bus.core_t} !== {1'b1, 32'd7, 32'd9, 32'd11}) begin errors++; $display("FAIL sim_launch: got %h exp %h", {bus.core_start, bus.core_n, bus.core_x, bus.core_t}, {1'b1, 32'd7, 32'd9, 32'd11}); end
    bus.core_done = 1'b1; bus.core_q = 32'hBAD;
    tick();
    bus.core_done = 1'b0;
    checks++; if ({bus.Q_valid, bus.busy} !== 2'b01) begin errors++; $display("FAIL sim_issue_done_ignored: got %b exp 01", {bus.Q_valid, bus.busy}); end
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'h55;
    tick();
    bus.core_done = 1'b0;
    checks++; if (bus.Q !== 32'h55) begin errors++; $display("FAIL sim_q: got %h exp %h", bus.Q, 32'h55); end
    tick();
    checks++; if (bus.job_count !== 16'd3) begin errors++; $display("FAIL sim_job_count: got %0d exp 3", bus.job_count); end
  endtask

  task automatic test_back_to_back();
    bus.T = 32'd12; bus.T_valid = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    checks++; if ({bus.core_n, bus.core_x, bus.core_t} !== {32'd7, 32'd9, 32'd12}) begin errors++; $display("FAIL b2b_sticky: got %h exp %h", {bus.core_n, bus.core_x, bus.core_t}, {32'd7, 32'd9, 32'd12}); end
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'h66;
    tick();
    bus.core_done = 1'b0;
    bus.T = 32'd13; bus.T_valid = 1'b1;
    checks++; if ({bus.Q, bus.T_ready} !== {32'h66, 1'b0}) begin errors++; $display("FAIL b2b_out: got %h exp %h", {bus.Q, bus.T_ready}, {32'h66, 1'b0}); end
    tick();
    checks++; if ({bus.job_count, bus.T_ready} !== {16'd4, 1'b1}) begin errors++; $display("FAIL b2b_idle: got %h exp %h", {bus.job_count, bus.T_ready}, {16'd4, 1'b1}); end
    tick();
    bus.T_valid = 1'b0;
    checks++; if ({bus.core_start, bus.core_t} !== {1'b1, 32'd13}) begin errors++; $display("FAIL b2b_second: got %h exp %h", {bus.core_start, bus.core_t}, {1'b1, 32'd13}); end
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'h77;
    tick();
    bus.core_done = 1'b0;
    tick();
    checks++; if (bus.job_count !== 16'd5) begin errors++; $display("FAIL b2b_job_count: got %0d exp 5", bus.job_count); end
  endtask

  task automatic test_reset_mid_job();
    bus.T = 32'd1; bus.T_valid = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.Q_valid, bus.job_count} !== {1'b0, 1'b0, 16'd0}) begin errors++; $display("FAIL mid_reset_state: got %h exp 0", {bus.busy, bus.Q_valid, bus.job_count}); end
    checks++; if ({bus.core_n, bus.core_x, bus.core_t} !== 96'h0) begin errors++; $display("FAIL mid_reset_operands: got %h exp 0", {bus.core_n, bus.core_x, bus.core_t}); end
    checks++; if (bus.N_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b exp 0", bus.N_ready); end
    tick();
    rst_n = 1'b1;
    bus.core_done = 1'b1; bus.core_q = 32'h88;
    tick();
    bus.core_done = 1'b0;
    tick();
    checks++; if ({bus.Q_valid, bus.busy, bus.T_ready, bus.N_ready} !== 4'b0001) begin errors++; $display("FAIL mid_reset_after: got %b exp 0001", {bus.Q_valid, bus.busy, bus.T_ready, bus.N_ready}); end
    checks++; if (bus.job_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count: got %0d exp 0", bus.job_count); end
  endtask

  task automatic test_watchdog();
`ifdef Q_SEQ_WATCHDOG_EN
    bit early;
    bus.X = 32'd1; bus.X_valid = 1'b1;
    tick();
    bus.X_valid = 1'b0;
    bus.T = 32'd1; bus.T_valid = 1'b1; bus.Q_ready = 1'b0;
    tick();
    bus.T_valid = 1'b0;
    tick();
    early = 1'b0;
    repeat (15) begin
      tick();
      if (bus.Q_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL wd_early: got %b exp 0", early); end
    tick();
    checks++; if ({bus.Q_valid, bus.Q, bus.err} !== {1'b1, 32'h7FC0_0000, 1'b1}) begin errors++; $display("FAIL wd_timeout: got %h exp %h", {bus.Q_valid, bus.Q, bus.err}, {1'b1, 32'h7FC0_0000, 1'b1}); end
    bus.Q_ready = 1'b1;
    tick();
    bus.T_valid = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    tick();
    bus.core_done = 1'b1; bus.core_q = 32'h42;
    tick();
    bus.core_done = 1'b0;
    checks++; if (bus.Q !== 32'h42) begin errors++; $display("FAIL wd_normal_q: got %h exp %h", bus.Q, 32'h42); end
    tick();
    checks++; if ({bus.err, bus.job_count} !== {1'b1, 16'd2}) begin errors++; $display("FAIL wd_err_sticky: got %h exp %h", {bus.err, bus.job_count}, {1'b1, 16'd2}); end
`else
    bus.X = 32'd1; bus.X_valid = 1'b1;
    tick();
    bus.X_valid = 1'b0;
    bus.T = 32'd1; bus.T_valid = 1'b1; bus.Q_ready = 1'b1;
    tick();
    bus.T_valid = 1'b0;
    repeat (40) tick();
    checks++; if ({bus.Q_valid, bus.busy, bus.err} !== 3'b010) begin errors++; $display("FAIL nowd_wait: got %b exp 010", {bus.Q_valid, bus.busy, bus.err}); end
    bus.core_done = 1'b1; bus.core_q = 32'h42;
    tick();
    bus.core_done = 1'b0;
    tick();
    checks++; if ({bus.err, bus.job_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL nowd_done: got %h exp %h", {bus.err, bus.job_count}, {1'b0, 16'd1}); end
`endif
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    start_cnt = 0;
    rst_n     = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_job();
    test_t_before_x();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_job();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running exp finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
